// File: rtl/img2col_reader.sv
// img2col reader: walks K x K stride-1 windows of a row-major image in ram_t0 and
// streams the elements as valid/ready column vectors through a 2-entry skid FIFO.
`ifndef DATA_WIDTH
`define DATA_WIDTH 8
`endif
`ifndef ADDR_SIZE
`define ADDR_SIZE 8
`endif

module img2col_reader #(
    parameter int unsigned DATA_WIDTH = `DATA_WIDTH,
    parameter int unsigned ADDR_SIZE  = `ADDR_SIZE,
    parameter int unsigned IMG_H      = 4,
    parameter int unsigned IMG_W      = 4,
    parameter int unsigned K          = 3
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    output logic                  busy,
    output logic                  done,
    output logic                  mem_en,
    output logic                  mem_we,
    output logic [ADDR_SIZE-1:0]  mem_addr,
    output logic [DATA_WIDTH-1:0] mem_din,
    input  logic [DATA_WIDTH-1:0] mem_dout,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_last
);
    localparam int unsigned OH      = IMG_H - K + 1;
    localparam int unsigned OW      = IMG_W - K + 1;
    localparam int unsigned DIM_MAX = (IMG_H > IMG_W) ? IMG_H : IMG_W;
    localparam int unsigned CW      = $clog2(DIM_MAX + 1);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

    state_t                state_q, state_d;
    logic [CW-1:0]         oy_q, oy_d, ox_q, ox_d, ky_q, ky_d, kx_q, kx_d;
    logic [ADDR_SIZE-1:0]  mem_addr_q, mem_addr_d, addr_row;
    logic                  mem_en_q, mem_en_d, busy_q, busy_d, done_q, done_d;
    logic                  inflight_q, inflight_d, infl_last_q, infl_last_d;
    logic [1:0]            fifo_cnt_q, fifo_cnt_d;
    logic [DATA_WIDTH-1:0] e0_data_q, e0_data_d, e1_data_q, e1_data_d;
    logic                  e0_last_q, e0_last_d, e1_last_q, e1_last_d;
    logic                  out_valid_q, out_valid_d;
    logic                  pop, push, issue, col_last, at_last;

    assign mem_we    = 1'b0;
    assign mem_din   = '0;
    assign mem_en    = mem_en_q;
    assign mem_addr  = mem_addr_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign out_valid = out_valid_q;
    assign out_data  = e0_data_q;
    assign out_last  = e0_last_q;

    always_comb begin
        state_d     = state_q;
        oy_d        = oy_q;
        ox_d        = ox_q;
        ky_d        = ky_q;
        kx_d        = kx_q;
        mem_addr_d  = mem_addr_q;
        inflight_d  = 1'b0;
        infl_last_d = infl_last_q;
        fifo_cnt_d  = fifo_cnt_q;
        e0_data_d   = e0_data_q;
        e1_data_d   = e1_data_q;
        e0_last_d   = e0_last_q;
        e1_last_d   = e1_last_q;
        addr_row    = '0;

        pop      = out_valid_q & out_ready;
        push     = inflight_q;
        col_last = (ky_q == CW'(K - 1)) && (kx_q == CW'(K - 1));
        at_last  = col_last && (ox_q == CW'(OW - 1)) && (oy_q == CW'(OH - 1));
        // Only issue when the returning read is guaranteed a FIFO slot.
        issue    = (state_q == S_RUN) &&
                   (({1'b0, fifo_cnt_q} + 3'(inflight_q) - 3'(pop)) < 3'd2);

        // Shift-register FIFO: entry 0 is always the head.
        case ({push, pop})
            2'b10: begin
                if (fifo_cnt_q == 2'd0) begin
                    e0_data_d = mem_dout;
                    e0_last_d = infl_last_q;
                end else begin
                    e1_data_d = mem_dout;
                    e1_last_d = infl_last_q;
                end
                fifo_cnt_d = fifo_cnt_q + 2'd1;
            end
            2'b01: begin
                e0_data_d  = e1_data_q;
                e0_last_d  = e1_last_q;
                fifo_cnt_d = fifo_cnt_q - 2'd1;
            end
            2'b11: begin
                if (fifo_cnt_q == 2'd1) begin
                    e0_data_d = mem_dout;
                    e0_last_d = infl_last_q;
                end else begin
                    e0_data_d = e1_data_q;
                    e0_last_d = e1_last_q;
                    e1_data_d = mem_dout;
                    e1_last_d = infl_last_q;
                end
            end
            default: ;
        endcase

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d    = S_RUN;
                    oy_d       = '0;
                    ox_d       = '0;
                    ky_d       = '0;
                    kx_d       = '0;
                    mem_addr_d = '0;
                end
            end
            S_RUN: begin
                if (issue) begin
                    inflight_d  = 1'b1;
                    infl_last_d = col_last;
                    if (at_last) begin
                        state_d = S_DRAIN;
                    end else begin
                        if (kx_q != CW'(K - 1)) begin
                            kx_d = kx_q + 1'b1;
                        end else begin
                            kx_d = '0;
                            if (ky_q != CW'(K - 1)) begin
                                ky_d = ky_q + 1'b1;
                            end else begin
                                ky_d = '0;
                                if (ox_q != CW'(OW - 1)) begin
                                    ox_d = ox_q + 1'b1;
                                end else begin
                                    ox_d = '0;
                                    oy_d = oy_q + 1'b1;
                                end
                            end
                        end
                        addr_row   = ADDR_SIZE'(oy_d) + ADDR_SIZE'(ky_d);
                        mem_addr_d = addr_row * ADDR_SIZE'(IMG_W) +
                                     ADDR_SIZE'(ox_d) + ADDR_SIZE'(kx_d);
                    end
                end
            end
            S_DRAIN: begin
                if (!inflight_q && (fifo_cnt_d == 2'd0)) begin
                    state_d = S_DONE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        out_valid_d = (fifo_cnt_d != 2'd0);
        busy_d      = (state_d != S_IDLE);
        done_d      = (state_d == S_DONE);
        mem_en_d    = (state_d == S_RUN) || (state_d == S_DRAIN);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            oy_q        <= '0;
            ox_q        <= '0;
            ky_q        <= '0;
            kx_q        <= '0;
            mem_addr_q  <= '0;
            mem_en_q    <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            inflight_q  <= 1'b0;
            infl_last_q <= 1'b0;
            fifo_cnt_q  <= '0;
            e0_data_q   <= '0;
            e1_data_q   <= '0;
            e0_last_q   <= 1'b0;
            e1_last_q   <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            oy_q        <= oy_d;
            ox_q        <= ox_d;
            ky_q        <= ky_d;
            kx_q        <= kx_d;
            mem_addr_q  <= mem_addr_d;
            mem_en_q    <= mem_en_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            inflight_q  <= inflight_d;
            infl_last_q <= infl_last_d;
            fifo_cnt_q  <= fifo_cnt_d;
            e0_data_q   <= e0_data_d;
            e1_data_q   <= e1_data_d;
            e0_last_q   <= e0_last_d;
            e1_last_q   <= e1_last_d;
            out_valid_q <= out_valid_d;
        end
    end
endmodule

// File: tb/tb_img2col_reader.sv
// Directed bench for img2col_reader: a 4x4/K=3 instance and a 5x5/K=1 instance,
// each fed by a behavioural 1-cycle-latency RAM holding mem[i] = i.
module tb_img2col_reader;
    localparam int unsigned DW = 8;
    localparam int unsigned AW = 8;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic          a_start = 1'b0, a_out_ready = 1'b0;
    logic          a_busy, a_done, a_mem_en, a_mem_we, a_out_valid, a_out_last;
    logic [AW-1:0] a_mem_addr;
    logic [DW-1:0] a_mem_din, a_mem_dout, a_out_data;

    logic          b_start = 1'b0, b_out_ready = 1'b0;
    logic          b_busy, b_done, b_mem_en, b_mem_we, b_out_valid, b_out_last;
    logic [AW-1:0] b_mem_addr;
    logic [DW-1:0] b_mem_din, b_mem_dout, b_out_data;

    logic [DW-1:0] ram [0:(1<<AW)-1];
    int checks = 0;
    int errors = 0;

    img2col_reader #(.DATA_WIDTH(DW), .ADDR_SIZE(AW), .IMG_H(4), .IMG_W(4), .K(3)) u_a (
        .clk(clk), .rst_n(rst_n), .start(a_start), .busy(a_busy), .done(a_done),
        .mem_en(a_mem_en), .mem_we(a_mem_we), .mem_addr(a_mem_addr), .mem_din(a_mem_din),
        .mem_dout(a_mem_dout), .out_valid(a_out_valid), .out_ready(a_out_ready),
        .out_data(a_out_data), .out_last(a_out_last));

    img2col_reader #(.DATA_WIDTH(DW), .ADDR_SIZE(AW), .IMG_H(5), .IMG_W(5), .K(1)) u_b (
        .clk(clk), .rst_n(rst_n), .start(b_start), .busy(b_busy), .done(b_done),
        .mem_en(b_mem_en), .mem_we(b_mem_we), .mem_addr(b_mem_addr), .mem_din(b_mem_din),
        .mem_dout(b_mem_dout), .out_valid(b_out_valid), .out_ready(b_out_ready),
        .out_data(b_out_data), .out_last(b_out_last));

    initial begin
        for (int i = 0; i < (1 << AW); i++) ram[i] = DW'(i);
    end

    always @(posedge clk) if (a_mem_en) a_mem_dout <= ram[a_mem_addr];
    always @(posedge clk) if (b_mem_en) b_mem_dout <= ram[b_mem_addr];

    // Address (and thus data) of element n for the 4x4 image, K=3: 2x2 windows of 9.
    function automatic int exp_a(input int n);
        int col, oy, ox, ky, kx;
        col = n / 9;
        oy  = col / 2;
        ox  = col % 2;
        ky  = (n % 9) / 3;
        kx  = n % 3;
        return (oy + ky) * 4 + ox + kx;
    endfunction

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if ({a_mem_en, a_out_valid, a_out_last, a_busy, a_done, a_mem_we} !== 6'd0)
            begin errors++; $display("FAIL reset_ctl_a got %b want 000000",
                {a_mem_en, a_out_valid, a_out_last, a_busy, a_done, a_mem_we}); end
        checks++;
        if (a_mem_addr !== 8'd0 || a_out_data !== 8'd0 || a_mem_din !== 8'd0)
            begin errors++; $display("FAIL reset_bus_a addr=%0h data=%0h din=%0h want 0",
                a_mem_addr, a_out_data, a_mem_din); end
        checks++;
        if ({b_mem_en, b_out_valid, b_busy, b_done} !== 4'd0)
            begin errors++; $display("FAIL reset_ctl_b got %b want 0000",
                {b_mem_en, b_out_valid, b_busy, b_done}); end
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_full_stream();
        int n = 0;
        int cyc;
        a_out_ready = 1'b1;
        a_start = 1'b1;
        @(negedge clk); a_start = 1'b0; cyc = 1;
        checks++;
        if (a_mem_en !== 1'b1 || a_mem_addr !== 8'd0 || a_busy !== 1'b1)
            begin errors++; $display("FAIL cycle1 en=%b addr=%0d busy=%b want 1 0 1",
                a_mem_en, a_mem_addr, a_busy); end
        @(negedge clk); cyc = 2;
        checks++;
        if (a_out_valid !== 1'b0)
            begin errors++; $display("FAIL early_valid got %b want 0", a_out_valid); end
        @(negedge clk); cyc = 3;
        checks++;
        if (a_out_valid !== 1'b1 || a_out_data !== 8'd0)
            begin errors++; $display("FAIL first_out valid=%b data=%0d want 1 0",
                a_out_valid, a_out_data); end
        while (n < 36 && cyc < 200) begin
            if (a_out_valid === 1'b1) begin
                checks++;
                if (a_out_data !== DW'(exp_a(n)) || a_out_last !== (n % 9 == 8))
                    begin errors++; $display("FAIL full_elem%0d data=%0d last=%b want %0d %b",
                        n, a_out_data, a_out_last, exp_a(n), (n % 9 == 8)); end
                if (n == 35) begin
                    checks++;
                    if (cyc != 38)
                        begin errors++; $display("FAIL last_elem_cycle got %0d want 38", cyc); end
                end
                n++;
            end
            @(negedge clk); cyc++;
        end
        checks++;
        if (n != 36) begin errors++; $display("FAIL full_count got %0d want 36", n); end
        checks++;
        if (a_done !== 1'b1 || a_busy !== 1'b1 || a_mem_en !== 1'b0)
            begin errors++; $display("FAIL done_cycle done=%b busy=%b en=%b want 1 1 0",
                a_done, a_busy, a_mem_en); end
        @(negedge clk);
        checks++;
        if (a_busy !== 1'b0 || a_done !== 1'b0)
            begin errors++; $display("FAIL idle_after busy=%b done=%b want 0 0", a_busy, a_done); end
    endtask

    task automatic test_random_ready();
        int n = 0;
        int guard = 0;
        bit en_ok = 1'b1;
        a_out_ready = 1'b0;
        a_start = 1'b1;
        @(negedge clk); a_start = 1'b0;
        while (n < 36 && guard < 1000) begin
            if (a_busy && !a_done && a_mem_en !== 1'b1) en_ok = 1'b0;
            a_out_ready = 1'($urandom_range(0, 1));
            if (a_out_valid === 1'b1 && a_out_ready) begin
                checks++;
                if (a_out_data !== DW'(exp_a(n)) || a_out_last !== (n % 9 == 8))
                    begin errors++; $display("FAIL rand_elem%0d data=%0d last=%b want %0d %b",
                        n, a_out_data, a_out_last, exp_a(n), (n % 9 == 8)); end
                n++;
            end
            @(negedge clk); guard++;
        end
        checks++;
        if (n != 36) begin errors++; $display("FAIL rand_count got %0d want 36", n); end
        checks++;
        if (!en_ok) begin errors++; $display("FAIL rand_mem_en dropped during job got 0 want 1"); end
        checks++;
        if (a_done !== 1'b1 || a_out_valid !== 1'b0)
            begin errors++; $display("FAIL rand_done done=%b valid=%b want 1 0", a_done, a_out_valid); end
        a_out_ready = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_stall();
        int n = 0;
        int guard = 0;
        bit stalled = 1'b0;
        a_out_ready = 1'b1;
        a_start = 1'b1;
        @(negedge clk); a_start = 1'b0;
        while (n < 36 && guard < 400) begin
            if (a_out_valid === 1'b1 && a_out_ready) begin
                checks++;
                if (a_out_data !== DW'(exp_a(n)) || a_out_last !== (n % 9 == 8))
                    begin errors++; $display("FAIL stall_elem%0d data=%0d want %0d",
                        n, a_out_data, exp_a(n)); end
                n++;
            end
            if (n == 10 && !stalled) begin
                stalled = 1'b1;
                @(negedge clk); a_out_ready = 1'b0;
                for (int s = 0; s < 20; s++) begin
                    @(negedge clk);
                    checks++;
                    if (a_out_valid !== 1'b1 || a_out_data !== DW'(exp_a(10)) || a_mem_en !== 1'b1)
                        begin errors++; $display("FAIL stall_hold%0d valid=%b data=%0d en=%b want 1 %0d 1",
                            s, a_out_valid, a_out_data, a_mem_en, exp_a(10)); end
                    checks++;
                    if (a_mem_addr !== AW'(exp_a(12)))
                        begin errors++; $display("FAIL stall_addr%0d got %0d want %0d",
                            s, a_mem_addr, exp_a(12)); end
                end
                checks++;
                if (u_a.fifo_cnt_q !== 2'd2)
                    begin errors++; $display("FAIL stall_fifo got %0d want 2", u_a.fifo_cnt_q); end
                a_out_ready = 1'b1;
            end else begin
                @(negedge clk);
            end
            guard++;
        end
        checks++;
        if (n != 36 || a_done !== 1'b1)
            begin errors++; $display("FAIL stall_end count=%0d done=%b want 36 1", n, a_done); end
        @(negedge clk);
    endtask

    task automatic test_start_ignored();
        int n = 0;
        int cyc = 1;
        int dones = 0;
        a_out_ready = 1'b1;
        a_start = 1'b1;
        @(negedge clk); a_start = 1'b0;
        while (n < 36 && cyc < 200) begin
            if (a_done === 1'b1) dones++;
            if (a_out_valid === 1'b1) n++;
            a_start = (cyc == 10);
            @(negedge clk); cyc++;
        end
        a_start = 1'b1;
        if (a_done === 1'b1) dones++;
        @(negedge clk); a_start = 1'b0;
        for (int i = 0; i < 5; i++) begin
            if (a_done === 1'b1) dones++;
            checks++;
            if (a_busy !== 1'b0)
                begin errors++; $display("FAIL start_in_done busy%0d got %b want 0", i, a_busy); end
            @(negedge clk);
        end
        checks++;
        if (n != 36 || dones != 1)
            begin errors++; $display("FAIL start_ignored count=%0d dones=%0d want 36 1", n, dones); end
    endtask

    task automatic test_reset_mid();
        int n = 0;
        int guard = 0;
        a_out_ready = 1'b1;
        a_start = 1'b1;
        @(negedge clk); a_start = 1'b0;
        while (n < 10 && guard < 100) begin
            if (a_out_valid === 1'b1) n++;
            @(negedge clk); guard++;
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if ({a_mem_en, a_out_valid, a_out_last, a_busy, a_done} !== 5'd0 ||
            a_mem_addr !== 8'd0 || a_out_data !== 8'd0)
            begin errors++; $display("FAIL reset_mid ctl=%b addr=%0d data=%0d want 0 0 0",
                {a_mem_en, a_out_valid, a_out_last, a_busy, a_done}, a_mem_addr, a_out_data); end
        @(negedge clk); rst_n = 1'b1;
        @(negedge clk);
        test_full_stream();
    endtask

    task automatic test_k1_back_to_back();
        b_out_ready = 1'b1;
        for (int job = 0; job < 2; job++) begin
            int n = 0;
            int guard = 0;
            @(negedge clk); b_start = 1'b1;
            @(negedge clk); b_start = 1'b0;
            while (n < 25 && guard < 200) begin
                if (b_out_valid === 1'b1) begin
                    checks++;
                    if (b_out_data !== DW'(n) || b_out_last !== 1'b1)
                        begin errors++; $display("FAIL k1_job%0d_elem%0d data=%0d last=%b want %0d 1",
                            job, n, b_out_data, b_out_last, n); end
                    n++;
                end
                @(negedge clk); guard++;
            end
            checks++;
            if (n != 25 || b_done !== 1'b1 || b_mem_en !== 1'b0)
                begin errors++; $display("FAIL k1_job%0d_end count=%0d done=%b en=%b want 25 1 0",
                    job, n, b_done, b_mem_en); end
        end
        @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_full_stream();
        test_random_ready();
        test_stall();
        test_start_ignored();
        test_reset_mid();
        test_k1_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout got running want finished");
        $fatal(1, "watchdog");
    end
endmodule
